// File: rtl/scroll_msg_ctrl_pkg.sv
//==============================================================================
// Module  : scroll_msg_pkg
// Brief   : Character, state and segment-pattern definitions for scroll_msg_ctrl.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package scroll_msg_pkg;

    typedef logic [4:0] char_t;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam char_t CHAR_BLANK  = 5'd31;
    localparam int    MSG_ROM_LEN = 16;
    localparam int    ROM_IDX_W   = $clog2(MSG_ROM_LEN);
    localparam int    MAX_MSG_LEN = 64;

    // Default message: 0-9 followed by A-F
    localparam char_t [0:MSG_ROM_LEN-1] MSG_ROM = {
        5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,
        5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15
    };

    // Active-low cathode patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;

    // Packs the default message into a flat vector, entry i at bits [5i +: 5]
    function automatic logic [5*MAX_MSG_LEN-1:0] msg_rom_packed();
        logic [5*MAX_MSG_LEN-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_MSG_LEN; i++) begin
            v[5*i +: 5] = MSG_ROM[ROM_IDX_W'(i % MSG_ROM_LEN)];
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scroll_msg_ctrl_if.sv
//==============================================================================
// Module  : scroll_msg_ctrl_if
// Brief   : Tick/run inputs and display outputs of scroll_msg_ctrl (dir with SCROLL_DIR_EN).
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

interface scroll_msg_ctrl_if #(
    parameter int MSG_LEN = 16
);
    localparam int POS_W = $clog2(MSG_LEN);

    logic             tick;
    logic             run;
`ifdef SCROLL_DIR_EN
    logic             dir;
`endif
    logic [6:0]       seg;
    logic [3:0]       an;
    logic [POS_W-1:0] pos;
    logic             wrap;

`ifdef SCROLL_DIR_EN
    modport master (output tick, run, dir, input  seg, an, pos, wrap);
    modport slave  (input  tick, run, dir, output seg, an, pos, wrap);
`else
    modport master (output tick, run, input  seg, an, pos, wrap);
    modport slave  (input  tick, run, output seg, an, pos, wrap);
`endif

endinterface

`default_nettype wire

// File: rtl/scroll_msg_ctrl_seg7_char_enc.sv
//==============================================================================
// Module  : seg7_char_enc
// Brief   : Combinational 5-bit character code to active-low seven-segment pattern.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg7_char_enc
    import scroll_msg_pkg::*;
(
    input  wire char_t      i_char,
    output logic [6:0]      o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_char)
            5'd0:    o_seg = SEG_0;
            5'd1:    o_seg = SEG_1;
            5'd2:    o_seg = SEG_2;
            5'd3:    o_seg = SEG_3;
            5'd4:    o_seg = SEG_4;
            5'd5:    o_seg = SEG_5;
            5'd6:    o_seg = SEG_6;
            5'd7:    o_seg = SEG_7;
            5'd8:    o_seg = SEG_8;
            5'd9:    o_seg = SEG_9;
            5'd10:   o_seg = SEG_A;
            5'd11:   o_seg = SEG_B;
            5'd12:   o_seg = SEG_C;
            5'd13:   o_seg = SEG_D;
            5'd14:   o_seg = SEG_E;
            5'd15:   o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/scroll_msg_ctrl.sv
//==============================================================================
// Module  : scroll_msg_ctrl
// Brief   : 4-digit scrolling-message controller; optional scroll direction
//           input enabled by macro SCROLL_DIR_EN.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module scroll_msg_ctrl
    import scroll_msg_pkg::*;
#(
    parameter int                        MSG_LEN     = 16,
    parameter int                        REFRESH_DIV = 100_000,
    parameter logic [5*MAX_MSG_LEN-1:0]  MSG_INIT    = msg_rom_packed()
)(
    input  wire logic          clkin,
    input  wire logic          rstn,
    scroll_msg_ctrl_if.slave   bus
);

    localparam int POS_W = $clog2(MSG_LEN);
    localparam int IDX_W = $clog2(MSG_LEN + 3);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   refresh_cnt_q, refresh_cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    char_t              w_rom [MSG_LEN];
    logic [IDX_W-1:0]   w_idx_raw;
    logic [IDX_W-1:0]   w_idx;
    logic [6:0]         w_seg;
    logic               w_advance;
    logic               w_down;

    for (genvar i = 0; i < MSG_LEN; i++) begin : g_rom
        assign w_rom[i] = MSG_INIT[5*i +: 5];
    end

    // Digit sel shows ROM[pos + 3 - sel]; sum never exceeds 2*MSG_LEN-1, so one subtract wraps it
    assign w_idx_raw = IDX_W'(pos_q) + IDX_W'(2'd3 - sel_q);
    assign w_idx     = (w_idx_raw >= IDX_W'(MSG_LEN)) ? (w_idx_raw - IDX_W'(MSG_LEN)) : w_idx_raw;

    seg7_char_enc u_enc (
        .i_char (w_rom[POS_W'(w_idx)]),
        .o_seg  (w_seg)
    );

`ifdef SCROLL_DIR_EN
    assign w_down = bus.dir;
`else
    assign w_down = 1'b0;
`endif

    assign w_advance = (state_q == RUN) && bus.run && bus.tick;

    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        wrap_d        = 1'b0;
        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        sel_d         = sel_q;

        if (refresh_cnt_q == CNT_LAST) begin
            refresh_cnt_d = '0;
            sel_d         = sel_q + 2'd1;
        end

        case (state_q)
            BLANK:   if (bus.run)  state_d = RUN;
            RUN:     if (!bus.run) state_d = HOLD;
            HOLD:    if (bus.run)  state_d = RUN;
            default: state_d = BLANK;
        endcase

        if (w_advance) begin
            if (w_down) begin
                pos_d  = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
                wrap_d = (pos_q == '0);
            end else begin
                pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                wrap_d = (pos_q == POS_LAST);
            end
        end

        an_d  = ~(4'b0001 << sel_q);
        seg_d = (state_q == BLANK) ? SEG_OFF : w_seg;
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q       <= BLANK;
            pos_q         <= '0;
            wrap_q        <= 1'b0;
            refresh_cnt_q <= '0;
            sel_q         <= 2'd0;
            seg_q         <= SEG_OFF;
            an_q          <= 4'hF;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            wrap_q        <= wrap_d;
            refresh_cnt_q <= refresh_cnt_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.pos  = pos_q;
    assign bus.wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_scroll_msg_ctrl.sv
//==============================================================================
// Module  : tb_scroll_msg_ctrl
// Brief   : Self-checking bench for scroll_msg_ctrl against a behavioural model.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_scroll_msg_ctrl;
    import scroll_msg_pkg::*;

    localparam int ML = 6;
    localparam int RD = 4;
    localparam logic [5*MAX_MSG_LEN-1:0] TB_ROM =
        {{(5*(MAX_MSG_LEN-ML)){1'b0}}, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    scroll_msg_ctrl_if #(.MSG_LEN(ML)) bus ();

    scroll_msg_ctrl #(
        .MSG_LEN     (ML),
        .REFRESH_DIV (RD),
        .MSG_INIT    (TB_ROM)
    ) dut (
        .clkin (clk),
        .rstn  (rstn),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: edges since reset, mode (0 blank, 1 scrolling, 2 held), window start
    int m_n     = 0;
    int m_state = 0;
    int m_pos   = 0;
    int rom [ML]       = '{1, 2, 3, 4, 5, 6};
    logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0: seg_of = 7'h40;
            1: seg_of = 7'h79;
            2: seg_of = 7'h24;
            3: seg_of = 7'h30;
            4: seg_of = 7'h19;
            5: seg_of = 7'h12;
            6: seg_of = 7'h02;
            7: seg_of = 7'h78;
            8: seg_of = 7'h00;
            9: seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_seg"},  32'(bus.seg),  32'h7F);
        chk({pfx, "_an"},   32'(bus.an),   32'hF);
        chk({pfx, "_pos"},  32'(bus.pos),  32'd0);
        chk({pfx, "_wrap"}, 32'(bus.wrap), 32'd0);
    endtask

    // Called #1 after an edge; asserts reset mid-cycle so the async path is exercised
    task automatic apply_reset(input string pfx);
        rstn = 1'b0;
        bus.tick = 1'b0;
        #1;
        chk_reset_vals({pfx, "_async"});
        @(posedge clk);
        #1;
        chk_reset_vals({pfx, "_held"});
        rstn    = 1'b1;
        m_n     = 0;
        m_state = 0;
        m_pos   = 0;
    endtask

    task automatic cycle(input bit t, input bit r, input bit d);
        int         sel;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        bit         e_wrap;
        bit         down;
        bus.tick = t;
        bus.run  = r;
`ifdef SCROLL_DIR_EN
        bus.dir  = d;
        down     = d;
`else
        down     = 1'b0;
`endif
        sel    = (m_n / RD) % 4;
        e_an   = an_tbl[sel];
        e_seg  = (m_state == 0) ? 7'h7F : seg_of(rom[(m_pos + 3 - sel) % ML]);
        e_wrap = 1'b0;
        if (m_state == 1 && r && t) begin
            if (down) begin
                m_pos  = (m_pos + ML - 1) % ML;
                e_wrap = (m_pos == ML - 1);
            end else begin
                m_pos  = (m_pos + 1) % ML;
                e_wrap = (m_pos == 0);
            end
        end
        if (m_state == 1) m_state = r ? 1 : 2;
        else if (r)       m_state = 1;
        m_n++;
        @(posedge clk);
        #1;
        chk("an",   32'(bus.an),   32'(e_an));
        chk("seg",  32'(bus.seg),  32'(e_seg));
        chk("pos",  32'(bus.pos),  32'(m_pos));
        chk("wrap", 32'(bus.wrap), 32'(e_wrap));
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.run  = 1'b0;
`ifdef SCROLL_DIR_EN
        bus.dir  = 1'b0;
`endif
        @(posedge clk);
        #1;
        apply_reset("rst_init");

        // Ticks while disabled stay blank and never advance
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end

        // Full scan of all four anodes with the window at pos 0
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0);

        // Five scroll steps, with a full scan at the final window
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0);

        // Wrap back to 0, then a tick coincident with run falling is dropped
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("hold_pos", 32'(bus.pos), 32'd0);

        // Resume, reach pos 3 with sel 2, then reset mid-scan
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16 && ((m_n / RD) % 4) != 2; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("mid_sel", 32'((m_n / RD) % 4), 32'd2);
        chk("mid_pos", 32'(bus.pos), 32'd3);
        apply_reset("rst_mid");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);

`ifdef SCROLL_DIR_EN
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("dir_dn_pos", 32'(bus.pos), 32'd5);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("dir_up_pos", 32'(bus.pos), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
`endif

        // Randomised run/tick/dir traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset("rst_rand");
            end else begin
                cycle($urandom_range(0, 3) == 0,
                      $urandom_range(0, 7) != 0,
                      $urandom_range(0, 1) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
